pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. Drives the enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM segment registers. Resolves load-use hazards, instruction- and data-bus stalls and exception flushes. Sequences multi-cycle multiply/divide occupancy of the EX stage with an internal counter FSM.

## Interface
Parameters:
- MUL_CYCLES, 2: BUSY-state cycles for a multiply; must be ≥1.
- DIV_CYCLES, 33: BUSY-state cycles for a divide; must be ≥1.
- CNT_W, 6: counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  the ID instruction actually reads rs / rt.
- ex_regwen  in  1  the EX instruction writes a register.
- ex_wreg  in  6  EX destination; bit5=1 means HI/LO and is never a GPR hazard.
- ex_load  in  1  the EX instruction is a load.
- ex_mul, ex_div  in  1 each  the EX instruction is a multiply / divide.
- div_done  in  1  divider result ready (used only with the macro).
- inst_stall, data_stall  in  1 each  instruction / data bus not ready.
- exc_flush  in  1  exception or ERET committed in MEM.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  segment load enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (all-zero) into the segment.
- muldiv_start  out  1  one-cycle start pulse to the mul/div unit.
- muldiv_busy  out  1  registered; FSM is in BUSY.

## Operation
- FSM states: IDLE, BUSY, DONE; counter cnt[CNT_W-1:0].
- IDLE→BUSY: on (ex_mul|ex_div) & !exc_flush & !data_stall.
  - Asserts muldiv_start.
  - Loads cnt = MUL_CYCLES-1 for a multiply, DIV_CYCLES-1 for a divide; ex_div wins if both are asserted.
- BUSY: if cnt==0 → DONE, else cnt decrements. The counter runs regardless of data_stall.
- DONE→IDLE: when !data_stall; otherwise stays in DONE. ex_mul and ex_div are ignored in DONE.
- md_hold = (IDLE & start condition) | BUSY.
- lu_hazard = ex_load & ex_regwen & !ex_wreg[5] & ex_wreg[4:0]!=0 & ((id_use_rs & id_rs==ex_wreg[4:0]) | (id_use_rt & id_rt==ex_wreg[4:0])).
- Output priority (first match wins; all unlisted enables are 1 and unlisted flushes are 0):
  1. resetn=0: all enables 0, all flushes 1, muldiv_start=0.
  2. exc_flush: all flushes 1, all enables 1. FSM forced to IDLE and cnt cleared next edge; no start is issued.
  3. data_stall: all enables 0, all flushes 0.
  4. md_hold: pc_en, if_id_en and id_ex_en are 0; ex_mem_flush=1.
  5. lu_hazard: pc_en=0, if_id_en=0, id_ex_flush=1.
  6. inst_stall: pc_en=0, if_id_flush=1.
- A flush is only meaningful with its enable at 1. A segment register with both en and flush asserted loads zero.

## Timing
- Enables and flushes are combinational from inputs, FSM state and resetn. muldiv_busy is registered.
- Reset values: FSM=IDLE, cnt=0, muldiv_busy=0. Enable and flush outputs are as in priority rule 1.
- Mul/div occupancy with no other stall: 1 start cycle + N BUSY cycles + 1 DONE cycle. The instruction leaves EX on the DONE edge, i.e. N+2 cycles in EX (4 for MUL_CYCLES=2, 35 for DIV_CYCLES=33).
- Load-use: exactly one bubble. The dependent instruction enters EX one cycle after the load leaves EX.
- exc_flush during BUSY: the operation is abandoned and the state is IDLE on the next cycle.
- resetn low mid-operation: the state is IDLE and cnt=0 at the next edge.

## Configuration
- DIV_EARLY_DONE_EN defined:
  - In BUSY for a divide, div_done=1 moves the FSM to DONE on the next edge regardless of cnt.
  - cnt==0 still forces DONE.
  - Requires one extra state bit recording mul vs div.
- DIV_EARLY_DONE_EN undefined: div_done is ignored; divide latency is fixed at DIV_CYCLES.

## Test plan
- Reset: resetn=0 for 2 cycles with ex_mul=1 → all enables 0, flushes 1, muldiv_start=0. After release, state is IDLE and muldiv_busy=0.
- Load-use: ex_load=1, ex_regwen=1, ex_wreg=6'd8, id_rs=8, id_use_rs=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. Repeat with ex_wreg=0 or 6'h28 → no stall.
- Multiply: ex_mul=1 held, MUL_CYCLES=2 → muldiv_start pulse in cycle 0; muldiv_busy=1 in cycles 1-2; DONE in cycle 3 with all enables 1; id_ex_en=0 in cycles 0-2.
- Divide with data_stall in DONE: DIV_CYCLES=33, data_stall=1 for 3 cycles at DONE → FSM stays in DONE with all enables 0, then returns to IDLE; no second muldiv_start.
- Exception mid-divide: exc_flush=1 in BUSY with cnt=20 → all flushes 1; next cycle IDLE, cnt=0, muldiv_busy=0.
- Early done (macro on): div_done=1 in BUSY cycle 5 → DONE in cycle 6. With the macro off, DONE arrives after 33 BUSY cycles.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline hazard and stall controller for the five-stage MIPS core.
// It generates the load enables and bubble (flush) controls for the PC, IF/ID,
// ID/EX and EX/MEM segment registers. It also sequences multi-cycle
// multiply/divide occupancy of the EX stage with a small counter FSM
// (IDLE -> BUSY -> DONE).
//
// Optional feature macro: DIV_EARLY_DONE_EN
//   When defined, div_done from the divider ends the BUSY phase of a divide
//   early. When undefined, div_done is ignored and the divide latency is fixed.
//
// Ports:
//   clk, resetn             clock; synchronous active-low reset
//   id_rs, id_rt            source register numbers of the ID instruction
//   id_use_rs, id_use_rt    ID instruction really reads rs / rt
//   ex_regwen, ex_wreg      EX writes a register; destination (bit5 = HI/LO)
//   ex_load                 EX instruction is a load
//   ex_mul, ex_div          EX instruction is a multiply / divide
//   div_done                divider result ready (early-done feature only)
//   inst_stall, data_stall  instruction / data bus not ready
//   exc_flush               exception or ERET committed in MEM
//   pc_en .. ex_mem_en      segment load enables (combinational)
//   *_flush                 load a bubble into the segment (combinational)
//   muldiv_start            one-cycle start pulse to the mul/div unit
//   muldiv_busy             registered, high while the FSM is in BUSY
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_regwen,
  input  logic [5:0] ex_wreg,
  input  logic       ex_load,
  input  logic       ex_mul,
  input  logic       ex_div,
  input  logic       div_done,
  input  logic       inst_stall,
  input  logic       data_stall,
  input  logic       exc_flush,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       muldiv_start,
  output logic       muldiv_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic start_s;
  logic md_hold_s;
  logic rs_match_s;
  logic rt_match_s;
  logic lu_hazard_s;
  logic busy_exit_s;

`ifdef DIV_EARLY_DONE_EN
  // Remembers whether the operation in flight is a divide, so that div_done
  // cannot cut a multiply short.
  logic is_div_q, is_div_d;
`else
  logic unused_div_done_s;
  assign unused_div_done_s = div_done;
`endif

  // Start of a mul/div: only from IDLE, and never while the pipe is being
  // flushed or frozen by the data bus (the instruction would not be in EX).
  assign start_s   = (state_q == ST_IDLE) & (ex_mul | ex_div) & ~exc_flush & ~data_stall;
  assign md_hold_s = start_s | (state_q == ST_BUSY);

  // Load-use hazard: HI/LO destinations (bit5) and $zero never create one.
  assign rs_match_s  = id_use_rs & (id_rs == ex_wreg[4:0]);
  assign rt_match_s  = id_use_rt & (id_rt == ex_wreg[4:0]);
  assign lu_hazard_s = ex_load & ex_regwen & ~ex_wreg[5] & (ex_wreg[4:0] != 5'd0)
                     & (rs_match_s | rt_match_s);

`ifdef DIV_EARLY_DONE_EN
  assign busy_exit_s = (cnt_q == CNT_ZERO) | (is_div_q & div_done);
`else
  assign busy_exit_s = (cnt_q == CNT_ZERO);
`endif

  // FSM next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!resetn || exc_flush) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_d = ST_BUSY;
            cnt_d   = ex_div ? DIV_LOAD : MUL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          // The counter keeps running under data_stall; the unit is
          // independent of the memory stage.
          if (busy_exit_s) begin
            state_d = ST_DONE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_DONE: begin
          // Hold DONE until the pipe can actually advance the result.
          if (!data_stall) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  assign busy_d = (state_d == ST_BUSY);

`ifdef DIV_EARLY_DONE_EN
  // Operation-type capture for the early-done path.
  always_comb begin
    is_div_d = is_div_q;
    if (!resetn || exc_flush) begin
      is_div_d = 1'b0;
    end else if (start_s) begin
      is_div_d = ex_div;
    end else begin
      is_div_d = is_div_q;
    end
  end

  // Operation-type register.
  always_ff @(posedge clk) begin
    is_div_q <= is_div_d;
  end
`endif

  // FSM state, counter and busy flag registers (reset handled in next-state).
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    busy_q  <= busy_d;
  end

  assign muldiv_busy = busy_q;

  // Segment enable / flush priority decode.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    muldiv_start = 1'b0;
    if (!resetn) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (exc_flush) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (data_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if (md_hold_s) begin
      // Freeze everything up to EX and push bubbles into MEM while the
      // multi-cycle op occupies EX.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
      muldiv_start = start_s;
    end else if (lu_hazard_s) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (inst_stall) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end else begin
      muldiv_start = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MULC = 2;
  localparam int DIVC = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [4:0] id_rs, id_rt;
  logic       id_use_rs, id_use_rt, ex_regwen, ex_load, ex_mul, ex_div, div_done;
  logic [5:0] ex_wreg;
  logic       inst_stall, data_stall, exc_flush;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, muldiv_start, muldiv_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Behavioural model: an operation is described by whether one is in
  // flight and the absolute cycle index of its last BUSY cycle.
  bit m_in_op    = 1'b0;
  bit m_is_div   = 1'b0;
  int m_busy_end = 0;

  pipe_hazard_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_regwen(ex_regwen), .ex_wreg(ex_wreg), .ex_load(ex_load),
    .ex_mul(ex_mul), .ex_div(ex_div), .div_done(div_done),
    .inst_stall(inst_stall), .data_stall(data_stall), .exc_flush(exc_flush),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_busy();
    return m_in_op && (cyc <= m_busy_end);
  endfunction

  function automatic bit m_start();
    return !m_in_op && (ex_mul || ex_div) && !exc_flush && !data_stall;
  endfunction

  // Expected {pc_en,if_id_en,id_ex_en,ex_mem_en,if_id_fl,id_ex_fl,ex_mem_fl,start,busy}
  function automatic logic [8:0] m_expect();
    logic [3:0] en;
    logic [2:0] fl;
    logic       st;
    bit         lu;
    en = 4'b1111;
    fl = 3'b000;
    st = 1'b0;
    lu = ex_load && ex_regwen && !ex_wreg[5] && (ex_wreg[4:0] != 5'd0) &&
         ((id_use_rs && id_rs == ex_wreg[4:0]) || (id_use_rt && id_rt == ex_wreg[4:0]));
    if (!resetn) begin
      en = 4'b0000; fl = 3'b111;
    end else if (exc_flush) begin
      fl = 3'b111;
    end else if (data_stall) begin
      en = 4'b0000;
    end else if (m_start() || m_busy()) begin
      en = 4'b0001; fl = 3'b001; st = m_start();
    end else if (lu) begin
      en = 4'b0011; fl = 3'b010;
    end else if (inst_stall) begin
      en = 4'b0111; fl = 3'b100;
    end
    return {en, fl, st, m_busy()};
  endfunction

  task automatic cycle_check();
    #1;
    chk("outputs", {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
                    ex_mem_flush, muldiv_start, muldiv_busy}, m_expect());
  endtask

  task automatic advance();
    bit st;
    @(posedge clk);
    st = m_start();
    if (!resetn || exc_flush) begin
      m_in_op = 1'b0;
    end else if (!m_in_op) begin
      if (st) begin
        m_in_op    = 1'b1;
        m_is_div   = ex_div;
        m_busy_end = cyc + (ex_div ? DIVC : MULC);
      end
    end else if (cyc <= m_busy_end) begin
`ifdef DIV_EARLY_DONE_EN
      if (m_is_div && div_done) m_busy_end = cyc;
`endif
    end else if (!data_stall) begin
      m_in_op = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_regwen = 1'b0; ex_wreg = 6'd0; ex_load = 1'b0; ex_mul = 1'b0; ex_div = 1'b0;
    div_done = 1'b0; inst_stall = 1'b0; data_stall = 1'b0; exc_flush = 1'b0;
  endtask

  initial begin
    int nb;
    resetn = 1'b0;
    clear_inputs();
    ex_mul = 1'b1;
    @(negedge clk);

    // Reset, two cycles with ex_mul held (state unknown before the first edge).
    #1;
    chk("rst_pc_en", pc_en, 0);
    chk("rst_flush", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b111);
    chk("rst_start", muldiv_start, 0);
    advance();
    cycle_check();
    chk("rst_en", {pc_en, if_id_en, id_ex_en, ex_mem_en}, 4'b0000);
    advance();
    resetn = 1'b1;
    ex_mul = 1'b0;
    cycle_check();
    chk("post_rst_busy", muldiv_busy, 0);
    chk("post_rst_cnt", dut.cnt_q, 0);
    advance();

    // Load-use hazard and its non-hazard variants.
    ex_load = 1'b1; ex_regwen = 1'b1; ex_wreg = 6'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    cycle_check();
    chk("lu_ctl", {pc_en, if_id_en, id_ex_en, id_ex_flush}, 4'b0011);
    advance();
    ex_wreg = 6'd0;
    cycle_check();
    chk("lu_r0", {pc_en, if_id_en, id_ex_flush}, 3'b110);
    advance();
    ex_wreg = 6'h28;
    cycle_check();
    chk("lu_hilo", {pc_en, if_id_en, id_ex_flush}, 3'b110);
    advance();
    clear_inputs();

    // Multiply held in EX: start, two BUSY cycles, DONE.
    ex_mul = 1'b1;
    cycle_check();
    chk("mul_c0", {muldiv_start, muldiv_busy, id_ex_en}, 3'b100);
    advance();
    for (int i = 1; i <= 2; i++) begin
      cycle_check();
      chk("mul_busy", {muldiv_start, muldiv_busy, id_ex_en}, 3'b010);
      advance();
    end
    cycle_check();
    chk("mul_done", {pc_en, if_id_en, id_ex_en, ex_mem_en, muldiv_start}, 5'b11110);
    advance();
    ex_mul = 1'b0;
    cycle_check();
    advance();

    // Divide with data_stall in DONE.
    ex_div = 1'b1;
    cycle_check();
    chk("div_start", muldiv_start, 1);
    advance();
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      cycle_check();
      if (!muldiv_busy) break;
      nb++;
      advance();
    end
    chk("div_busy_len", nb, DIVC);
    data_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) cycle_check();
      else #1;
      chk("div_done_stall", {pc_en, if_id_en, id_ex_en, ex_mem_en, muldiv_start}, 5'b00000);
      advance();
    end
    data_stall = 1'b0;
    ex_div = 1'b0;
    cycle_check();
    chk("div_done_go", {pc_en, if_id_en, id_ex_en, ex_mem_en, muldiv_start}, 5'b11110);
    advance();
    ex_div = 1'b1;
    cycle_check();
    chk("div_idle_after", {muldiv_start, muldiv_busy}, 2'b10);
    advance();

    // Exception in BUSY when the counter has reached 20.
    for (int i = 1; i < 13; i++) begin
      cycle_check();
      advance();
    end
    exc_flush = 1'b1;
    cycle_check();
    chk("exc_cnt20", dut.cnt_q, 20);
    chk("exc_ctl", {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush},
        7'b1111111);
    advance();
    exc_flush = 1'b0;
    ex_div = 1'b0;
    cycle_check();
    chk("exc_after", {muldiv_busy, muldiv_start}, 2'b00);
    chk("exc_cnt0", dut.cnt_q, 0);
    advance();

    // div_done in BUSY cycle 5.
    ex_div = 1'b1;
    cycle_check();
    advance();
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      div_done = (nb == 4);
      cycle_check();
      if (!muldiv_busy) break;
      nb++;
      advance();
    end
    div_done = 1'b0;
    ex_div = 1'b0;
`ifdef DIV_EARLY_DONE_EN
    chk("early_len", nb, 5);
`else
    chk("early_len", nb, DIVC);
`endif
    advance();

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      resetn     = ($urandom_range(0, 99) != 0);
      exc_flush  = ($urandom_range(0, 49) == 0);
      data_stall = ($urandom_range(0, 6) == 0);
      inst_stall = ($urandom_range(0, 6) == 0);
      ex_mul     = ($urandom_range(0, 9) == 0);
      ex_div     = ($urandom_range(0, 19) == 0);
      div_done   = ($urandom_range(0, 9) == 0);
      ex_load    = $urandom_range(0, 1);
      ex_regwen  = $urandom_range(0, 1);
      ex_wreg    = {($urandom_range(0, 4) == 0), 3'b000, 2'($urandom_range(0, 3))};
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_use_rs  = $urandom_range(0, 1);
      id_use_rt  = $urandom_range(0, 1);
      cycle_check();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
